// File: rtl/fpu_share_arbiter.sv
// Shares one fmul and one fadd core among NREQ requesters. Each unit has its
// own round-robin arbiter, registered core drive and a tag pipeline that routes
// every result back to the requester that issued it.
module fpu_share_arbiter #(
   parameter int unsigned WIDTH   = 11,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned ADD_LAT = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [NREQ-1:0]         i_req_op,
   input  logic [NREQ*WIDTH-1:0]   i_req_x,
   input  logic [NREQ*WIDTH-1:0]   i_req_y,
   output logic [NREQ-1:0]         o_req_ready,
   output logic [NREQ-1:0]         o_mul_resp_valid,
   output logic [WIDTH-1:0]        o_mul_resp_r,
   output logic [NREQ-1:0]         o_add_resp_valid,
   output logic [WIDTH-1:0]        o_add_resp_r,
   output logic [WIDTH-1:0]        o_fmul_x,
   output logic [WIDTH-1:0]        o_fmul_y,
   output logic                    o_fmul_ce,
   input  logic [WIDTH-1:0]        i_fmul_r,
   output logic [WIDTH-1:0]        o_fadd_x,
   output logic [WIDTH-1:0]        o_fadd_y,
   output logic                    o_fadd_ce,
   input  logic [WIDTH-1:0]        i_fadd_r,
   output logic                    o_mul_busy,
   output logic                    o_add_busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // First eligible index at or above ptr, wrapping; returned one-hot.
   function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] elig,
                                                input logic [IW-1:0]   ptr);
      logic [NREQ-1:0] gnt;
      logic            done;
      int unsigned     j;
      logic [IW-1:0]   jj;
      gnt  = '0;
      done = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = 32'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         jj = IW'(j);
         if (!done && elig[jj]) begin
            gnt[jj] = 1'b1;
            done    = 1'b1;
         end
      end
      return gnt;
   endfunction

   function automatic logic [IW-1:0] gnt_index(input logic [NREQ-1:0] gnt);
      logic [IW-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) idx = IW'(i);
      end
      return idx;
   endfunction

   function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
      return (idx == IW'(NREQ - 1)) ? '0 : IW'(idx + 1'b1);
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NREQ-1:0] oh;
      for (int unsigned i = 0; i < NREQ; i++) begin
         oh[i] = (IW'(i) == idx);
      end
      return oh;
   endfunction

   // Multiply unit state
   logic [IW-1:0]             r_mul_ptr;
   logic [MUL_LAT:0]          r_mul_tv;
   logic [MUL_LAT:0][IW-1:0]  r_mul_ti;
   logic [WIDTH-1:0]          r_fmul_x, r_fmul_y;
   logic                      r_fmul_ce;
   logic [NREQ-1:0]           r_mul_rv;
   logic [WIDTH-1:0]          r_mul_rr;

   // Add unit state
   logic [IW-1:0]             r_add_ptr;
   logic [ADD_LAT:0]          r_add_tv;
   logic [ADD_LAT:0][IW-1:0]  r_add_ti;
   logic [WIDTH-1:0]          r_fadd_x, r_fadd_y;
   logic                      r_fadd_ce;
   logic [NREQ-1:0]           r_add_rv;
   logic [WIDTH-1:0]          r_add_rr;

   logic [NREQ-1:0]  w_mul_gnt, w_add_gnt;
   logic             w_mul_acc, w_add_acc;
   logic [IW-1:0]    w_mul_idx, w_add_idx;
   logic [WIDTH-1:0] w_mul_x, w_mul_y, w_add_x, w_add_y;

   // Independent round-robin grants; nothing is granted while in reset.
   always_comb begin
      w_mul_gnt = '0;
      w_add_gnt = '0;
      if (!i_rst) begin
         w_mul_gnt = rr_grant(i_req_valid & ~i_req_op, r_mul_ptr);
         w_add_gnt = rr_grant(i_req_valid & i_req_op, r_add_ptr);
      end
      w_mul_acc   = |w_mul_gnt;
      w_add_acc   = |w_add_gnt;
      w_mul_idx   = gnt_index(w_mul_gnt);
      w_add_idx   = gnt_index(w_add_gnt);
      o_req_ready = w_mul_gnt | w_add_gnt;
   end

   // Operand select; zero when the unit has no accept this cycle.
   always_comb begin
      w_mul_x = '0;
      w_mul_y = '0;
      w_add_x = '0;
      w_add_y = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (w_mul_gnt[i]) begin
            w_mul_x = i_req_x[i*WIDTH +: WIDTH];
            w_mul_y = i_req_y[i*WIDTH +: WIDTH];
         end
         if (w_add_gnt[i]) begin
            w_add_x = i_req_x[i*WIDTH +: WIDTH];
            w_add_y = i_req_y[i*WIDTH +: WIDTH];
         end
      end
   end

   // Multiply unit: pointer, core drive, tag pipeline and response register.
   // ce is 0 only when every tag stage is empty, so shifting unconditionally
   // is equivalent to shifting on ce. Stage MUL_LAT lines up with fmul_r valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mul_ptr <= '0;
         r_mul_tv  <= '0;
         r_mul_ti  <= '0;
         r_fmul_x  <= '0;
         r_fmul_y  <= '0;
         r_fmul_ce <= 1'b0;
         r_mul_rv  <= '0;
         r_mul_rr  <= '0;
      end else begin
         if (w_mul_acc) r_mul_ptr <= ptr_after(w_mul_idx);
         r_fmul_x  <= w_mul_x;
         r_fmul_y  <= w_mul_y;
         r_fmul_ce <= w_mul_acc | (|r_mul_tv[MUL_LAT-1:0]);
         r_mul_tv  <= {r_mul_tv[MUL_LAT-1:0], w_mul_acc};
         r_mul_ti  <= {r_mul_ti[MUL_LAT-1:0], w_mul_idx};
         if (r_mul_tv[MUL_LAT]) begin
            r_mul_rr <= i_fmul_r;
            r_mul_rv <= onehot(r_mul_ti[MUL_LAT]);
         end else begin
            r_mul_rv <= '0;
         end
      end
   end

   // Add unit: same structure as the multiply unit with ADD_LAT stages.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_add_ptr <= '0;
         r_add_tv  <= '0;
         r_add_ti  <= '0;
         r_fadd_x  <= '0;
         r_fadd_y  <= '0;
         r_fadd_ce <= 1'b0;
         r_add_rv  <= '0;
         r_add_rr  <= '0;
      end else begin
         if (w_add_acc) r_add_ptr <= ptr_after(w_add_idx);
         r_fadd_x  <= w_add_x;
         r_fadd_y  <= w_add_y;
         r_fadd_ce <= w_add_acc | (|r_add_tv[ADD_LAT-1:0]);
         r_add_tv  <= {r_add_tv[ADD_LAT-1:0], w_add_acc};
         r_add_ti  <= {r_add_ti[ADD_LAT-1:0], w_add_idx};
         if (r_add_tv[ADD_LAT]) begin
            r_add_rr <= i_fadd_r;
            r_add_rv <= onehot(r_add_ti[ADD_LAT]);
         end else begin
            r_add_rv <= '0;
         end
      end
   end

   // Registered outputs and busy flags.
   always_comb begin
      o_fmul_x         = r_fmul_x;
      o_fmul_y         = r_fmul_y;
      o_fmul_ce        = r_fmul_ce;
      o_fadd_x         = r_fadd_x;
      o_fadd_y         = r_fadd_y;
      o_fadd_ce        = r_fadd_ce;
      o_mul_resp_valid = r_mul_rv;
      o_mul_resp_r     = r_mul_rr;
      o_add_resp_valid = r_add_rv;
      o_add_resp_r     = r_add_rr;
      o_mul_busy       = (|r_mul_tv) | r_fmul_ce;
      o_add_busy       = (|r_add_tv) | r_fadd_ce;
   end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: directed scenarios then random traffic, all
// checked against a transaction-level model (grant order plus response queues).
module tb_fpu_share_arbiter;

   localparam int W  = 11;
   localparam int N  = 4;
   localparam int ML = 2;
   localparam int AL = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_op, req_ready;
   logic [N*W-1:0] req_x, req_y;
   logic [N-1:0]   mul_resp_valid, add_resp_valid;
   logic [W-1:0]   mul_resp_r, add_resp_r;
   logic [W-1:0]   fmul_x, fmul_y, fmul_r, fadd_x, fadd_y, fadd_r;
   logic           fmul_ce, fadd_ce, mul_busy, add_busy;

   always #5 clk = ~clk;

   fpu_share_arbiter #(.WIDTH(W), .NREQ(N), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .i_req_op(req_op), .i_req_x(req_x), .i_req_y(req_y),
      .o_req_ready(req_ready),
      .o_mul_resp_valid(mul_resp_valid), .o_mul_resp_r(mul_resp_r),
      .o_add_resp_valid(add_resp_valid), .o_add_resp_r(add_resp_r),
      .o_fmul_x(fmul_x), .o_fmul_y(fmul_y), .o_fmul_ce(fmul_ce), .i_fmul_r(fmul_r),
      .o_fadd_x(fadd_x), .o_fadd_y(fadd_y), .o_fadd_ce(fadd_ce), .i_fadd_r(fadd_r),
      .o_mul_busy(mul_busy), .o_add_busy(add_busy)
   );

   // Stand-in core arithmetic; any fixed function of the operands will do.
   function automatic logic [W-1:0] f_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      if (x == 11'h2A0 && y == 11'h2A0) return 11'h311;
      return x ^ W'(y << 3) ^ 11'h155;
   endfunction

   function automatic logic [W-1:0] f_add(input logic [W-1:0] x, input logic [W-1:0] y);
      return W'(x + y + 11'd1);
   endfunction

   // Core stubs: pipelines that advance only on ce.
   logic [W-1:0] mpipe [ML];
   logic [W-1:0] apipe [AL];
   always @(posedge clk) begin
      if (fmul_ce) begin
         for (int i = ML - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
         mpipe[0] <= f_mul(fmul_x, fmul_y);
      end
      if (fadd_ce) begin
         for (int i = AL - 1; i > 0; i--) apipe[i] <= apipe[i-1];
         apipe[0] <= f_add(fadd_x, fadd_y);
      end
   end
   assign fmul_r = mpipe[ML-1];
   assign fadd_r = apipe[AL-1];

   // Reference model state
   typedef struct {
      int           due;
      int           idx;
      logic [W-1:0] data;
   } ent_t;
   ent_t         mq[$];
   ent_t         aq[$];
   int           m_mptr, m_aptr, cyc;
   logic [W-1:0] m_mlast, m_alast, m_mx, m_my, m_ax, m_ay;
   int           vectors = 0;
   int           miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] elig, input int ptr);
      int j;
      for (int k = 0; k < N; k++) begin
         j = (ptr + k) % N;
         if (((elig >> j) & 1) != 0) return j;
      end
      return -1;
   endfunction

   task automatic check_outputs();
      logic [N-1:0] ev;
      logic [W-1:0] er;
      ev = '0;
      er = m_mlast;
      if (mq.size() > 0 && mq[0].due == cyc) begin
         ev      = N'(1) << mq[0].idx;
         er      = mq[0].data;
         m_mlast = er;
         void'(mq.pop_front());
      end
      chk("mul_resp_valid", 32'(mul_resp_valid), 32'(ev));
      chk("mul_resp_r", 32'(mul_resp_r), 32'(er));
      chk("mul_busy", 32'(mul_busy), 32'(mq.size() != 0));
      chk("fmul_ce", 32'(fmul_ce), 32'(mq.size() != 0));
      chk("fmul_x", 32'(fmul_x), 32'(m_mx));
      chk("fmul_y", 32'(fmul_y), 32'(m_my));
      ev = '0;
      er = m_alast;
      if (aq.size() > 0 && aq[0].due == cyc) begin
         ev      = N'(1) << aq[0].idx;
         er      = aq[0].data;
         m_alast = er;
         void'(aq.pop_front());
      end
      chk("add_resp_valid", 32'(add_resp_valid), 32'(ev));
      chk("add_resp_r", 32'(add_resp_r), 32'(er));
      chk("add_busy", 32'(add_busy), 32'(aq.size() != 0));
      chk("fadd_ce", 32'(fadd_ce), 32'(aq.size() != 0));
      chk("fadd_x", 32'(fadd_x), 32'(m_ax));
      chk("fadd_y", 32'(fadd_y), 32'(m_ay));
   endtask

   // One clock cycle: check registered outputs, drive inputs, check the
   // combinational grant, advance the model, then cross the edge.
   task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] op,
                       input logic [N*W-1:0] x, input logic [N*W-1:0] y);
      int           gm, ga;
      logic [N-1:0] er;
      check_outputs();
      rst = r; req_valid = v; req_op = op; req_x = x; req_y = y;
      #1;
      gm = r ? -1 : pick(v & ~op, m_mptr);
      ga = r ? -1 : pick(v & op, m_aptr);
      er = '0;
      if (gm >= 0) er = er | (N'(1) << gm);
      if (ga >= 0) er = er | (N'(1) << ga);
      chk("req_ready", 32'(req_ready), 32'(er));
      if (r) begin
         mq.delete(); aq.delete();
         m_mptr = 0; m_aptr = 0;
         m_mlast = '0; m_alast = '0;
         m_mx = '0; m_my = '0; m_ax = '0; m_ay = '0;
      end else begin
         m_mx = '0; m_my = '0; m_ax = '0; m_ay = '0;
         if (gm >= 0) begin
            m_mx = x[gm*W +: W];
            m_my = y[gm*W +: W];
            mq.push_back('{due: cyc + ML + 2, idx: gm, data: f_mul(m_mx, m_my)});
            m_mptr = (gm + 1) % N;
         end
         if (ga >= 0) begin
            m_ax = x[ga*W +: W];
            m_ay = y[ga*W +: W];
            aq.push_back('{due: cyc + AL + 2, idx: ga, data: f_add(m_ax, m_ay)});
            m_aptr = (ga + 1) % N;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
   endtask

   function automatic logic [N*W-1:0] rnd_ops();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[N*W-1:0];
   endfunction

   initial begin
      logic [N-1:0] one;
      one = 4'b0001;
      rst = 1'b1; req_valid = '0; req_op = '0; req_x = '0; req_y = '0;
      repeat (2) @(posedge clk);
      #1;
      cyc = 0;
      mq.delete(); aq.delete();
      m_mptr = 0; m_aptr = 0;
      m_mlast = '0; m_alast = '0;
      m_mx = '0; m_my = '0; m_ax = '0; m_ay = '0;

      // Reset state
      step(1'b1, '0, '0, '0, '0);

      // Single multiply: response three edges after the accept edge
      step(1'b0, 4'b0001, 4'b0000, 44'h2A0, 44'h2A0);
      idle(3);
      chk("single_mul_valid", 32'(mul_resp_valid), 32'h1);
      chk("single_mul_r", 32'(mul_resp_r), 32'h311);
      idle(1);
      chk("single_mul_busy_low", 32'(mul_busy), 32'h0);

      // Fairness: four back-to-back multiply requesters
      step(1'b1, '0, '0, '0, '0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 4'b1111, 4'b0000, rnd_ops(), rnd_ops());
         chk("fair_next_grant", 32'(req_ready), 32'(one << ((k + 1) % N)));
      end
      idle(6);

      // Concurrent units: req1 multiplies, req2 adds
      step(1'b0, 4'b0110, 4'b0100, rnd_ops(), rnd_ops());
      idle(6);

      // Same-requester collision: add then multiply from req3
      step(1'b0, 4'b1000, 4'b1000, rnd_ops(), rnd_ops());
      step(1'b0, 4'b1000, 4'b0000, rnd_ops(), rnd_ops());
      idle(3);
      chk("collide_add_valid", 32'(add_resp_valid), 32'h8);
      chk("collide_mul_valid", 32'(mul_resp_valid), 32'h8);
      idle(4);

      // Pointer wrap and skip
      step(1'b1, '0, '0, '0, '0);
      step(1'b0, 4'b0100, 4'b0000, rnd_ops(), rnd_ops());
      step(1'b0, 4'b0101, 4'b0000, rnd_ops(), rnd_ops());
      chk("wrap_then_req2", 32'(req_ready), 32'h4);
      step(1'b0, 4'b0101, 4'b0000, rnd_ops(), rnd_ops());
      idle(6);

      // Reset mid-flight
      step(1'b0, 4'b0001, 4'b0000, rnd_ops(), rnd_ops());
      step(1'b0, 4'b0010, 4'b0000, rnd_ops(), rnd_ops());
      step(1'b0, 4'b0100, 4'b0100, rnd_ops(), rnd_ops());
      step(1'b1, '0, '0, '0, '0);
      chk("rst_mul_busy", 32'(mul_busy), 32'h0);
      chk("rst_add_busy", 32'(add_busy), 32'h0);
      idle(5);
      step(1'b0, 4'b0101, 4'b0000, rnd_ops(), rnd_ops());
      idle(6);

      // Random traffic with occasional reset
      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 63) == 0), N'($urandom()), N'($urandom()),
              rnd_ops(), rnd_ops());
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Shares one external flopoco floating-point multiplier and one external flopoco adder among `NREQ` requesters, such as several MAC lanes or FSM-driven datapath fragments. Each cycle it grants at most one multiply and one add by independent round-robin arbitration, then drives the registered operand/`ce` ports of each core. It tracks every in-flight operation with a tag pipeline and returns each result to the requester that issued it. It sits between the scheduled datapath and the shared `fmul`/`fadd` cores.

## Interface
- `WIDTH`, default 11: flopoco word width (wE=4, wF=4, plus 3 exception/sign bits).
- `NREQ`, default 4: number of requesters, at least 2.
- `MUL_LAT`, default 2: fmul cycles from the edge that loads x/y (with ce=1) to the edge at which `fmul_r` is valid.
- `ADD_LAT`, default 3: same measure for fadd.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NREQ: requester i presents an operation.
- `req_op` in NREQ: per requester; 0 = multiply, 1 = add.
- `req_x`, `req_y` in NREQ*WIDTH: operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready` out NREQ: grant, combinational from `req_valid`, `req_op` and the round-robin pointers.
- `mul_resp_valid` out NREQ: one-hot; the multiply result for requester i is on `mul_resp_r`.
- `mul_resp_r` out WIDTH: registered multiply result.
- `add_resp_valid` out NREQ: one-hot; the add result for requester i is on `add_resp_r`.
- `add_resp_r` out WIDTH: registered add result.
- `fmul_x`, `fmul_y` out WIDTH, `fmul_ce` out 1: registered multiplier drive.
- `fmul_r` in WIDTH: multiplier result.
- `fadd_x`, `fadd_y` out WIDTH, `fadd_ce` out 1: registered adder drive.
- `fadd_r` in WIDTH: adder result.
- `mul_busy`, `add_busy` out 1: at least one operation is in flight in that unit.

## Operation
- There are two independent arbiters: MUL arbitrates over requesters with `req_valid & ~req_op`, and ADD over `req_valid & req_op`.
- Each arbiter holds a round-robin pointer `ptr`, reset to 0. It grants the first eligible index searching from `ptr` upward, wrapping modulo NREQ.
- On a grant to index g, `ptr` becomes (g+1) mod NREQ. Without a grant, `ptr` holds.
- A requester issues at most one operation per cycle. At most one `req_ready` bit per unit is high.
- An accept is the cycle `req_valid[i] & req_ready[i]`. At that edge:
  - the unit's x/y registers load the requester's operands and the unit's ce register is set to 1;
  - tag stage 0 loads {valid=1, idx=g}.
- Without an accept, x/y load 0 and tag stage 0 loads valid=0.
- The unit's ce output is 1 while an accept is registered or any tag stage is valid, and 0 otherwise. This keeps pipeline advance aligned with tag shifting.
- The tag pipeline has depth LAT per unit (MUL_LAT or ADD_LAT) and shifts every cycle ce is 1.
  - When the last stage is valid, the resp register loads `*_r` and `*_resp_valid` becomes one-hot at idx.
  - Otherwise `*_resp_valid` is 0 and `*_resp_r` holds its previous value.
- Responses have no backpressure. A requester must accept a result in the cycle it is valid.
- One requester may receive a multiply and an add response in the same cycle, on the separate channels.
- `*_busy` is the OR of the tag-stage valid bits plus the registered ce.

## Timing
- `req_ready` is combinational. Operands are sampled at the accept edge T.
- Core operand ports show the new values from T to T+1. The core result is valid after edge T+LAT. `*_resp_valid` is asserted during the cycle after edge T+LAT+1.
- Accept-to-response latency is LAT+1 cycles. Throughput is one operation per unit per cycle.
- Reset values: all ce, x/y, resp_r, resp_valid and busy outputs are 0. Tags are invalid and both `ptr` are 0. `req_ready` is 0 while `rst` is high.
- Reset mid-operation: in-flight operations are discarded and no response is produced for them. The first accept after reset is the first cycle with `rst` low.

## Test plan
- Single multiply: req0 op=0, x=0x2A0, y=0x2A0 accepted at T, with a model fmul returning 0x311 at T+2. Required: `mul_resp_valid`=0001 and `mul_resp_r`=0x311 in the cycle after edge T+3, and `mul_busy` low afterwards.
- Fairness: all four requesters issue back-to-back multiplies. Required: grants 0,1,2,3,0,… with one accept per cycle and responses in the same order, each 3 cycles after its accept.
- Concurrent units: req1 multiplies and req2 adds in the same cycle. Required: both are granted; the multiply responds after 3 cycles, the add after 4, and `ptr`s advance independently.
- Same-requester collision: req3 issues an add at T and a multiply at T+1. Required: in cycle T+4 both `add_resp_valid`=1000 and `mul_resp_valid`=1000, with correct data on each.
- Pointer wrap and skip: the MUL pointer is at 3, and req0 and req2 are requesting. Required: req0 is granted and `ptr` becomes 1; the next cycle, req2 is granted.
- Reset mid-flight: assert `rst` one cycle after three accepts. Required: no `*_resp_valid` for those operations, outputs 0, and the next accept is granted to index 0 with the first eligible index.
